// File: rtl/dsp_pkg.sv
// Shared helpers for the dispatch ID allocators: age compare, popcounts and default queue depths.
package dsp_pkg;

  localparam int unsigned ROB_DEPTH = 128;
  localparam int unsigned LDQ_DEPTH = 32;
  localparam int unsigned STQ_DEPTH = 32;

  // a is older than b; idw is the full ID width, its MSB being the wrap bit
  function automatic logic id_older(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned idw);
    logic [31:0] mask;
    mask = (32'd1 << (idw - 1)) - 32'd1;
    if (a[idw-1] != b[idw-1]) return (a & mask) >= (b & mask);
    else                      return (a & mask) <  (b & mask);
  endfunction

  function automatic int unsigned popcnt(input logic [31:0] v, input int unsigned n);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n && v[i]) c = c + 1;
    end
    return c;
  endfunction

  // number of set bits strictly below position lane
  function automatic int unsigned prefix_popcnt(input logic [31:0] v, input int unsigned lane);
    return popcnt(v, lane);
  endfunction

endpackage

// File: rtl/dsp_idq_prefix_cnt.sv
// Per-lane exclusive prefix popcount plus total, used for both allocation offsets and retire counts.
module dsp_idq_prefix_cnt
  import dsp_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CW    = 8
) (
  input  logic [LANES-1:0]    i_vld,
  output logic [LANES*CW-1:0] o_off,
  output logic [CW-1:0]       o_total
);

  always_comb begin
    o_off = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      o_off[i*CW +: CW] = CW'(prefix_popcnt(32'(i_vld), i));
    end
    o_total = CW'(popcnt(32'(i_vld), LANES));
  end

endmodule

// File: rtl/dsp_idq_alloc.sv
// Circular wrap-tagged ID allocator: compacted multi-lane allocation, multi-lane retire,
// and age-resolved rollback of the allocation pointer on trap / mispredict / replay flush.
module dsp_idq_alloc
  import dsp_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter int unsigned DEPTH    = ROB_DEPTH,
  parameter int unsigned IDW      = $clog2(DEPTH) + 1,
  parameter int unsigned MIS_KEEP = 1,
  parameter int unsigned LS_KEEP  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_trap_flush,
  input  logic                 i_mis_flush,
  input  logic [IDW-1:0]       i_mis_id,
  input  logic                 i_ls_flush,
  input  logic [IDW-1:0]       i_ls_id,
  input  logic                 i_stall,
  input  logic [LANES-1:0]     i_req_vld,
  input  logic [LANES-1:0]     i_ret_vld,
  output logic [LANES*IDW-1:0] o_id,
  output logic [IDW-1:0]       o_dsp_id,
  output logic [IDW-1:0]       o_ret_id,
  output logic [IDW-1:0]       o_cnt,
  output logic                 o_alloc_rdy,
  output logic                 o_full,
  output logic                 o_empty
);

  logic [IDW-1:0]       dsp_ptr_q, dsp_ptr_d;
  logic [IDW-1:0]       ret_ptr_q, ret_ptr_d;
  logic [LANES*IDW-1:0] req_off, ret_off;
  logic [IDW-1:0]       req_total, ret_total;
  logic [IDW-1:0]       cnt, free_cnt, tm, tl, mis_rel, ls_rel;
  logic                 any_flush, alloc_fire, ret_contig;

  dsp_idq_prefix_cnt #(.LANES(LANES), .CW(IDW)) u_req_cnt (
    .i_vld   (i_req_vld),
    .o_off   (req_off),
    .o_total (req_total)
  );

  dsp_idq_prefix_cnt #(.LANES(LANES), .CW(IDW)) u_ret_cnt (
    .i_vld   (i_ret_vld),
    .o_off   (ret_off),
    .o_total (ret_total)
  );

  always_comb begin
    cnt         = dsp_ptr_q - ret_ptr_q;
    free_cnt    = IDW'(DEPTH) - cnt;
    o_cnt       = cnt;
    o_dsp_id    = dsp_ptr_q;
    o_ret_id    = ret_ptr_q;
    o_alloc_rdy = free_cnt >= req_total;
    o_full      = free_cnt < IDW'(LANES);
    o_empty     = cnt == '0;
    o_id        = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      o_id[i*IDW +: IDW] = dsp_ptr_q + req_off[i*IDW +: IDW];
    end
  end

  always_comb begin
    any_flush  = i_trap_flush | i_mis_flush | i_ls_flush;
    alloc_fire = (|i_req_vld) & ~i_stall & o_alloc_rdy & ~any_flush;
    tm         = i_mis_id + IDW'(MIS_KEEP);
    tl         = i_ls_id + IDW'(LS_KEEP);
    ret_ptr_d  = ret_ptr_q + ret_total;
    dsp_ptr_d  = dsp_ptr_q;
    // trap rollback targets the post-retire pointer so same-cycle retires are not resurrected
    if (i_trap_flush)                  dsp_ptr_d = ret_ptr_d;
    else if (i_mis_flush && i_ls_flush) dsp_ptr_d = id_older(32'(tm), 32'(tl), IDW) ? tm : tl;
    else if (i_mis_flush)              dsp_ptr_d = tm;
    else if (i_ls_flush)               dsp_ptr_d = tl;
    else if (alloc_fire)               dsp_ptr_d = dsp_ptr_q + req_total;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_ptr_q <= '0;
      ret_ptr_q <= '0;
    end else begin
      dsp_ptr_q <= dsp_ptr_d;
      ret_ptr_q <= ret_ptr_d;
    end
  end

  // a set retire bit is contiguous from bit 0 iff its prefix count equals its lane number
  always_comb begin
    ret_contig = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i_ret_vld[i] && ret_off[i*IDW +: IDW] != IDW'(i)) ret_contig = 1'b0;
    end
    mis_rel = i_mis_id - ret_ptr_q;
    ls_rel  = i_ls_id - ret_ptr_q;
  end

  a_ret_le_cnt: assert property (@(posedge clk) disable iff (rst) ret_total <= cnt);
  a_ret_contig: assert property (@(posedge clk) disable iff (rst) ret_contig);
  a_mis_range:  assert property (@(posedge clk) disable iff (rst) !i_mis_flush || mis_rel < cnt);
  a_ls_range:   assert property (@(posedge clk) disable iff (rst) !i_ls_flush || ls_rel < cnt);

endmodule

// File: tb/tb_dsp_idq_alloc.sv
// Bench for dsp_idq_alloc at LANES=4, DEPTH=8: directed vector table, hand sequences, random vs model.
module tb_dsp_idq_alloc;

  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_trap_flush, i_mis_flush, i_ls_flush, i_stall;
  logic [IDW-1:0]   i_mis_id, i_ls_id;
  logic [LANES-1:0] i_req_vld, i_ret_vld;
  logic [LANES*IDW-1:0] o_id;
  logic [IDW-1:0]   o_dsp_id, o_ret_id, o_cnt;
  logic             o_alloc_rdy, o_full, o_empty;

  always #5 clk = ~clk;

  dsp_idq_alloc #(.LANES(LANES), .DEPTH(DEPTH), .IDW(IDW), .MIS_KEEP(1), .LS_KEEP(0)) dut (
    .clk(clk), .rst(rst),
    .i_trap_flush(i_trap_flush), .i_mis_flush(i_mis_flush), .i_mis_id(i_mis_id),
    .i_ls_flush(i_ls_flush), .i_ls_id(i_ls_id), .i_stall(i_stall),
    .i_req_vld(i_req_vld), .i_ret_vld(i_ret_vld),
    .o_id(o_id), .o_dsp_id(o_dsp_id), .o_ret_id(o_ret_id), .o_cnt(o_cnt),
    .o_alloc_rdy(o_alloc_rdy), .o_full(o_full), .o_empty(o_empty)
  );

  int checks = 0;
  int errors = 0;
  int ret_m, cnt_m;

  typedef struct {
    logic [3:0]  req, ret;
    logic        stall, trap, mis;
    logic [3:0]  mis_id;
    logic        ls;
    logic [3:0]  ls_id;
    logic        rdy;
    logic [15:0] ids;
    logic [3:0]  dsp, rid, cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int pc(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic vec_t mk(input logic [3:0] req, ret, input logic stall, trap, mis,
                              input logic [3:0] mid, input logic ls, input logic [3:0] lid,
                              input logic rdy, input logic [15:0] ids,
                              input logic [3:0] dsp, rid, cnt);
    vec_t v;
    v.req = req; v.ret = ret; v.stall = stall; v.trap = trap; v.mis = mis;
    v.mis_id = mid; v.ls = ls; v.ls_id = lid; v.rdy = rdy; v.ids = ids;
    v.dsp = dsp; v.rid = rid; v.cnt = cnt;
    return v;
  endfunction

  task automatic set_in(input logic r, input logic [3:0] req, ret, input logic stall, trap, mis,
                        input logic [3:0] mid, input logic ls, input logic [3:0] lid);
    @(negedge clk);
    rst = r; i_req_vld = req; i_ret_vld = ret; i_stall = stall; i_trap_flush = trap;
    i_mis_flush = mis; i_mis_id = mid; i_ls_flush = ls; i_ls_id = lid;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    tick();
  endtask

  task automatic cmp_model(input string tag);
    int k = 0;
    chk({tag, "_dsp"}, o_dsp_id, (ret_m + cnt_m) % 16);
    chk({tag, "_ret"}, o_ret_id, ret_m);
    chk({tag, "_cnt"}, o_cnt, cnt_m);
    chk({tag, "_full"}, o_full, (DEPTH - cnt_m) < LANES);
    chk({tag, "_empty"}, o_empty, cnt_m == 0);
    chk({tag, "_rdy"}, o_alloc_rdy, (DEPTH - cnt_m) >= pc(i_req_vld));
    for (int l = 0; l < LANES; l++) begin
      if (i_req_vld[l]) begin
        chk({tag, "_id"}, o_id[l*IDW +: IDW], (ret_m + cnt_m + k) % 16);
        k++;
      end
    end
  endtask

  initial begin
    int n, pm, pl, lenm, lenl, newlen, p;
    logic r, tr, mi, ls, st;
    logic [3:0] rq;
    vec_t v;

    //                req    ret   stl trp mis mid   ls  lid  rdy ids       dsp   rid   cnt
    tbl[0]  = mk(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h3210, 4'h4, 4'h0, 4'h4);
    tbl[1]  = mk(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h7654, 4'h8, 4'h0, 4'h8);
    tbl[2]  = mk(4'h1, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 16'h0008, 4'h8, 4'h0, 4'h8);
    tbl[3]  = mk(4'h3, 4'h7, 0, 0, 0, 4'h0, 0, 4'h0, 0, 16'h0098, 4'h8, 4'h3, 4'h5);
    tbl[4]  = mk(4'h3, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h0098, 4'hA, 4'h3, 4'h7);
    tbl[5]  = mk(4'h0, 4'hF, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h0000, 4'hA, 4'h7, 4'h3);
    tbl[6]  = mk(4'h0, 4'h7, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h0000, 4'hA, 4'hA, 4'h0);
    tbl[7]  = mk(4'hA, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'hB0A0, 4'hC, 4'hA, 4'h2);
    tbl[8]  = mk(4'h3, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h00DC, 4'hE, 4'hC, 4'h2);
    tbl[9]  = mk(4'h0, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h0000, 4'hE, 4'hE, 4'h0);
    tbl[10] = mk(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h10FE, 4'h2, 4'hE, 4'h4);
    tbl[11] = mk(4'hF, 4'h0, 0, 0, 1, 4'h0, 1, 4'hF, 1, 16'h5432, 4'hF, 4'hE, 4'h1);
    tbl[12] = mk(4'h0, 4'h1, 0, 1, 0, 4'h0, 0, 4'h0, 1, 16'h0000, 4'hF, 4'hF, 4'h0);
    tbl[13] = mk(4'h1, 4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1, 16'h000F, 4'hF, 4'hF, 4'h0);
    tbl[14] = mk(4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1, 16'h210F, 4'h3, 4'hF, 4'h4);

    // reset state, sampled with all lanes requesting but stalled
    set_in(1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    tick();
    for (int l = 0; l < LANES; l++) chk($sformatf("rst_id%0d", l), o_id[l*IDW +: IDW], l);
    chk("rst_dsp", o_dsp_id, 0);
    chk("rst_ret", o_ret_id, 0);
    chk("rst_cnt", o_cnt, 0);
    chk("rst_full", o_full, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_rdy", o_alloc_rdy, 1);

    for (int t = 0; t < 15; t++) begin
      v = tbl[t];
      set_in(1'b0, v.req, v.ret, v.stall, v.trap, v.mis, v.mis_id, v.ls, v.ls_id);
      chk($sformatf("tbl%0d_rdy", t), o_alloc_rdy, v.rdy);
      for (int l = 0; l < LANES; l++)
        if (v.req[l]) chk($sformatf("tbl%0d_id%0d", t, l), o_id[l*IDW +: IDW], v.ids[l*4 +: 4]);
      tick();
      chk($sformatf("tbl%0d_dsp", t), o_dsp_id, v.dsp);
      chk($sformatf("tbl%0d_ret", t), o_ret_id, v.rid);
      chk($sformatf("tbl%0d_cnt", t), o_cnt, v.cnt);
      chk($sformatf("tbl%0d_full", t), o_full, v.cnt > 4);
      chk($sformatf("tbl%0d_empty", t), o_empty, v.cnt == 0);
    end

    // simultaneous flush: live 2..7, mis 5 (keep -> 6) vs ls 4 (discard -> 4)
    do_reset();
    set_in(1'b0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    set_in(1'b0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    set_in(1'b0, 4'h0, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    set_in(1'b0, 4'hF, 4'h0, 0, 0, 1, 4'h5, 1, 4'h4); tick();
    chk("sflush_dsp", o_dsp_id, 4);
    chk("sflush_ret", o_ret_id, 2);
    chk("sflush_cnt", o_cnt, 2);

    // trap with same-cycle retire: live 0..5
    do_reset();
    set_in(1'b0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    set_in(1'b0, 4'h3, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    set_in(1'b0, 4'h0, 4'h3, 0, 1, 0, 4'h0, 0, 4'h0); tick();
    chk("trap_ret", o_ret_id, 2);
    chk("trap_dsp", o_dsp_id, 2);
    chk("trap_empty", o_empty, 1);

    // reset mid-operation overrides a pending allocation
    set_in(1'b0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    set_in(1'b1, 4'hF, 4'h3, 0, 0, 0, 4'h0, 0, 4'h0); tick();
    chk("midrst_dsp", o_dsp_id, 0);
    chk("midrst_ret", o_ret_id, 0);

    // randomized traffic against a length/offset model of the live window
    do_reset();
    ret_m = 0; cnt_m = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom % 100) == 0;
      rq = 4'($urandom % 16);
      st = ($urandom % 5) == 0;
      tr = ($urandom % 25) == 0;
      mi = (cnt_m > 0) && (($urandom % 10) == 0);
      ls = (cnt_m > 0) && (($urandom % 10) == 0);
      pm = (cnt_m > 0) ? $urandom_range(0, cnt_m - 1) : 0;
      pl = (cnt_m > 0) ? $urandom_range(0, cnt_m - 1) : 0;
      lenm = pm + 1;
      lenl = pl;
      // a window spanning exactly DEPTH is ambiguous to the wrap-bit age compare
      if (mi && ls && (lenm - lenl) == DEPTH) ls = 1'b0;
      n = $urandom_range(0, (cnt_m < 4) ? cnt_m : 4);
      newlen = cnt_m;
      if (mi) newlen = lenm;
      if (ls && lenl < newlen) newlen = lenl;
      if (!tr && (mi || ls) && n > newlen) n = newlen;
      set_in(r, rq, 4'((1 << n) - 1), st, tr, mi, 4'((ret_m + pm) % 16), ls, 4'((ret_m + pl) % 16));
      cmp_model($sformatf("rnd%0d", c));
      tick();
      if (r) begin
        ret_m = 0; cnt_m = 0;
      end else if (tr) begin
        ret_m = (ret_m + n) % 16; cnt_m = 0;
      end else if (mi || ls) begin
        ret_m = (ret_m + n) % 16; cnt_m = newlen - n;
      end else begin
        p = pc(rq);
        if (p > 0 && !st && (DEPTH - cnt_m) >= p) cnt_m = cnt_m + p;
        cnt_m = cnt_m - n;
        ret_m = (ret_m + n) % 16;
      end
    end
    cmp_model("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
